// File: rtl/decrypt_if.sv
// Start/stop handshake plus key and data memory ports of the decrypt engine.
`timescale 1ns/1ps
interface decrypt_if;
    logic [1:0]  start;
    logic [7:0]  length;
    logic [2:0]  stop;
    logic [7:0]  key_addr;
    logic [31:0] key_in;
    logic [8:0]  data_addr;
    logic [31:0] data_in;
    logic [31:0] decrypt_data;
    logic        we;

    modport master (
        output start, length, key_in, data_in,
        input  stop, key_addr, data_addr, decrypt_data, we
    );

    modport slave (
        input  start, length, key_in, data_in,
        output stop, key_addr, data_addr, decrypt_data, we
    );
endinterface

// File: rtl/decrypt_engine.sv
// Recovers plaintext words from the upper data region into the lower region, in groups of up
// to four words buffered so the single data port alternates between read and write bursts.
`timescale 1ns/1ps
module decrypt_engine #(
    parameter logic [8:0] READ_BASE  = 9'd256,
    parameter logic [8:0] WRITE_BASE = 9'd0
) (
    input logic       clk,
    input logic       reset,
    decrypt_if.slave  bus
);

    typedef enum logic [2:0] {StIdle, StRd, StDrain, StWr, StDone} state_e;

    state_e          state_q, state_d;
    logic [7:0]      i_q, i_d;
    logic [7:0]      w_q, w_d;
    logic [7:0]      len_q, len_d;
    logic [1:0]      slot_q, slot_d;
    logic            armed_q, armed_d;
    logic            lossy_q, lossy_d;
    logic [2:0]      stop_q, stop_d;
    logic            cap_vld_q, cap_vld_d;
    logic [1:0]      cap_op_q, cap_op_d;
    logic [1:0]      cap_slot_q, cap_slot_d;
    logic [3:0][31:0] buf_q, buf_d;
    logic [31:0]     plain;

    // Inverse of the encrypt op; op 1 was an AND and cannot be undone.
    always_comb begin
        plain = bus.data_in;
        unique case (cap_op_q)
            2'd0: plain = bus.data_in - bus.key_in;
            2'd1: plain = bus.data_in;
            2'd2: plain = bus.data_in + bus.key_in;
            2'd3: plain = bus.data_in ^ bus.key_in;
            default: plain = bus.data_in;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        w_d        = w_q;
        len_d      = len_q;
        slot_d     = slot_q;
        armed_d    = armed_q;
        lossy_d    = lossy_q;
        stop_d     = stop_q;
        cap_vld_d  = 1'b0;
        cap_op_d   = cap_op_q;
        cap_slot_d = cap_slot_q;
        buf_d      = buf_q;

        // Memory data arrives one cycle after its address, so capture is pipelined behind RD.
        if (cap_vld_q) begin
            buf_d[cap_slot_q] = plain;
            if (cap_op_q == 2'd1) lossy_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start != 2'b01) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d = 1'b0;
                    len_d   = bus.length;
                    i_d     = '0;
                    w_d     = '0;
                    slot_d  = '0;
                    lossy_d = 1'b0;
                    stop_d  = 3'b001;
                    state_d = (bus.length == 8'd0) ? StDone : StRd;
                end
            end
            StRd: begin
                cap_vld_d  = 1'b1;
                cap_op_d   = i_q[1:0];
                cap_slot_d = slot_q;
                i_d        = i_q + 8'd1;
                slot_d     = slot_q + 2'd1;
                if (slot_q == 2'd3 || (i_q + 8'd1) == len_q) state_d = StDrain;
            end
            StDrain: begin
                slot_d  = '0;
                state_d = StWr;
            end
            StWr: begin
                w_d    = w_q + 8'd1;
                slot_d = slot_q + 2'd1;
                if ((w_q + 8'd1) == i_q) begin
                    slot_d  = '0;
                    state_d = (i_q == len_q) ? StDone : StRd;
                end
            end
            StDone: begin
                stop_d  = lossy_q ? 3'b110 : 3'b010;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            i_q        <= '0;
            w_q        <= '0;
            len_q      <= '0;
            slot_q     <= '0;
            armed_q    <= 1'b1;
            lossy_q    <= 1'b0;
            stop_q     <= 3'b000;
            cap_vld_q  <= 1'b0;
            cap_op_q   <= '0;
            cap_slot_q <= '0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            w_q        <= w_d;
            len_q      <= len_d;
            slot_q     <= slot_d;
            armed_q    <= armed_d;
            lossy_q    <= lossy_d;
            stop_q     <= stop_d;
            cap_vld_q  <= cap_vld_d;
            cap_op_q   <= cap_op_d;
            cap_slot_q <= cap_slot_d;
            buf_q      <= buf_d;
        end
    end

    assign bus.we           = (state_q == StWr);
    assign bus.data_addr    = bus.we ? (WRITE_BASE + {1'b0, w_q}) : (READ_BASE + {1'b0, i_q});
    assign bus.key_addr     = i_q;
    assign bus.decrypt_data = buf_q[slot_q];
    assign bus.stop         = stop_q;

endmodule

// File: doc/decrypt_engine.md
# decrypt_engine

Inverse of the word encryption engine: on a start handshake it reads a block of encrypted words from the data memory's upper region, recovers each plaintext word using the key memory and the word's position-dependent operation, and writes the results back to the lower region. It sits beside the encrypt block on the same key memory and single-port data memory, uses the same start/stop handshake, and is driven by the same controller. Reads and writes are grouped through a 4-entry buffer, because the data port can either read or write in a given cycle.

## Interface
- READ_BASE, 9'd256, first data address of the encrypted block.
- WRITE_BASE, 9'd0, first data address for recovered plaintext.
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low.
- start  input  2  command; 2'b01 requests decryption, all other values mean idle.
- length  input  8  word count, sampled when start is accepted; 0 is legal.
- stop  output  3  status: 3'b001 ack, 3'b010 done, 3'b110 done with a lossy word.
- key_addr  output  8  key memory address.
- key_in  input  32  key word, valid the cycle after key_addr.
- data_addr  output  9  data memory address.
- data_in  input  32  data word, valid the cycle after data_addr (read cycles only).
- decrypt_data  output  32  write data, valid while we=1.
- we  output  1  data memory write enable.

## Operation
- **States:** IDLE, RD, DRAIN, WR, DONE.
- **Counters:**
  - i: word index, 8 bits, counts 0..length-1.
  - k: group size, k = min(4, words remaining).
  - b: buffer read slot.
  - w: write index, 8 bits.
- **IDLE:**
  - Accept when start==2'b01 and the engine is armed.
  - On accept: latch length, clear i, w, b and the lossy flag, and register stop<=3'b001.
  - Go to DONE if length==0, else to RD.
- **Arming:** the engine is armed after reset, and re-armed once start!=2'b01 is sampled in IDLE. A start held at 01 across done does not retrigger.
- **RD, one cycle per word, k cycles:**
  - key_addr=i[7:0].
  - data_addr=READ_BASE+i, modulo 512.
  - i increments each cycle.
- **Capture:** in the cycle after each RD address (RD or DRAIN), buf[slot] <= f(op, data_in, key_in), where op=i[1:0] of that word.
- **Operation f by op:**
  - op 0: data_in - key_in.
  - op 1: data_in, passed through unchanged (AND is not invertible). Sets the lossy flag.
  - op 2: data_in + key_in.
  - op 3: data_in ^ key_in.
  - All arithmetic is 32-bit modulo 2^32.
- **DRAIN:** one cycle that captures the last word of the group. Next state is WR.
- **WR, k cycles:**
  - we=1.
  - data_addr=WRITE_BASE+w, modulo 512.
  - decrypt_data=buf[j], for j=0..k-1.
  - w increments each cycle.
  - Next state is RD if words remain, else DONE.
- **DONE:** one cycle. Register stop<=3'b110 if lossy, else 3'b010. Next state is IDLE.
- **stop:** holds its value until the next accept.
- **Outside WR:** we=0 and data_addr shows the read address, which is READ_BASE+i.
- **Buffer:** buf and the write mux are registers; decrypt_data is buf[j].

## Timing
- **Reset values:**
  - stop=3'b000, key_addr=0, data_addr=READ_BASE, decrypt_data=0, we=0.
  - State IDLE, armed, buffer cleared.
- **Reset mid-operation:** takes effect immediately (asynchronous). we drops without waiting for a clock edge, no partial group is completed, and the engine re-arms.
- **Reference timeline:** start is sampled in cycle 0.
  - stop=001 is visible from cycle 1.
  - For L words in G=ceil(L/4) groups, each group costs 2k+1 cycles.
  - DONE occurs in cycle 2L+G+1.
  - stop=done is visible from cycle 2L+G+2.
- **length=0:** cycle 1 is DONE, and stop=010 is visible from cycle 2.
- **Port discipline:**
  - The memory port is never read and written in the same cycle.
  - Keys are read only in RD cycles.

## Test plan
1. **Mixed ops, length=4.**
   - Memory: key[0..3]={0x10,x,0x08,0x0F}; data[256..259]={0x15,0xF0,0x20,0xFF}.
   - Required: we in cycles 6-9, writing addr0..3 = {0x05,0xF0,0x28,0xF0}.
   - Required: stop=110 from cycle 11.
2. **length=1, no lossy word.**
   - Memory: key 0x1, data 0x0.
   - Required: addr0 = 0xFFFFFFFF (subtraction wraps).
   - Required: stop=010 from cycle 5, with no lossy bit.
3. **length=6, two groups.**
   - Required: we in cycles 6-9 and 13-14, addresses 0-5 in order.
   - Required: DONE in cycle 15, stop=110 from cycle 16.
   - Required: no read address appears while we=1.
4. **length=0.**
   - Required: stop=001 in cycle 1, 010 in cycle 2, and we never asserts.
5. **start held at 01 after done.**
   - Required: no second ack.
   - Then drop start for 1 cycle and raise it again: a new ack follows, and the lossy flag is cleared.
6. **Reset asserted during a WR cycle.**
   - Required: immediately we=0, stop=000, data_addr=256.
   - After release, a fresh start with length=4 completes as in test 1.
